pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 8'd255, memory-wait cycles before bus error.
REQ-002 SHALL have parameter TRAP_ADDR, default 32'h0000_0000, PC redirect target on bus error.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports de_rs1_addr, de_rs2_addr  input  5 each  decode-stage source register indices.
REQ-006 SHALL have ports de_rs1_used, de_rs2_used  input  1 each  decode instruction reads rs1/rs2.
REQ-007 SHALL have ports ex_wr_reg_en  input  1, ex_wr_reg_addr  input  5, ex_is_load  input  1  ALU-stage destination info.
REQ-008 SHALL have ports ex_jump_req  input  1, ex_jump_addr  input  32  ALU-stage taken branch/jump.
REQ-009 SHALL have port ex_mc_busy  input  1  ALU multi-cycle operation not yet done.
REQ-010 SHALL have ports lsu_req  input  1, lsu_ack  input  1  LSU data-bus request/acknowledge.
REQ-011 SHALL have port stall_o  output  5  hold per stage: [0] pc, [1] ifu_de, [2] de_alu, [3] alu_lsu, [4] lsu_wb.
REQ-012 SHALL have port flush_o  output  4  load NOP into: [0] ifu_de, [1] de_alu, [2] alu_lsu, [3] lsu_wb.
REQ-013 SHALL have ports pc_jump_en  output  1, pc_jump_addr  output  32  PC redirect to ifu.
REQ-014 SHALL have port bus_err_o  output  1  one-cycle pulse on memory timeout.

Function
REQ-015 SHALL implement FSM states RUN, MEM_WAIT, ERR; stall/flush/jump outputs combinational from state and inputs.
REQ-016 SHALL, in RUN, evaluate conditions by priority: memory wait > multi-cycle > jump > load-use > none.
REQ-017 SHALL treat memory wait as lsu_req && !lsu_ack: stall_o=5'b01111, flush_o=4'b1000; next state MEM_WAIT, counter=1.
REQ-018 SHALL treat ex_mc_busy: stall_o=5'b00111, flush_o=4'b0100; state stays RUN, counter unchanged.
REQ-019 SHALL treat ex_jump_req: pc_jump_en=1, pc_jump_addr=ex_jump_addr, flush_o=4'b0011, stall_o=0.
REQ-020 SHALL detect load-use as ex_is_load && ex_wr_reg_en && ex_wr_reg_addr!=0 && ((de_rs1_used && de_rs1_addr==ex_wr_reg_addr) || (de_rs2_used && de_rs2_addr==ex_wr_reg_addr)): stall_o=5'b00011, flush_o=4'b0010 (exactly one bubble).
REQ-021 SHALL drive stall_o=0, flush_o=0, pc_jump_en=0, pc_jump_addr=0 when no condition holds.
REQ-022 SHALL suppress jump and load-use effects while a higher-priority stall is active; the held ALU instruction re-presents them after release.
REQ-023 SHALL, in MEM_WAIT with !lsu_ack, drive stall_o=5'b01111, flush_o=4'b1000 and increment counter (8-bit).
REQ-024 SHALL, in MEM_WAIT with lsu_ack, release same cycle (stall_o=0, flush_o=0), clear counter, return to RUN.
REQ-025 SHALL, in MEM_WAIT when counter==TIMEOUT_CYC and !lsu_ack, go to ERR; lsu_ack in that cycle wins (RUN).
REQ-026 SHALL, in ERR (one cycle): bus_err_o=1, pc_jump_en=1, pc_jump_addr=TRAP_ADDR, flush_o=4'b1111, stall_o=0; next RUN, counter=0.
REQ-027 SHALL never assert stall_o[k] without stall_o[j] for all j<k.

Reset
REQ-028 SHALL, while rst_n=0, force state RUN, counter 0, and all outputs 0 regardless of inputs.
REQ-029 SHALL abandon MEM_WAIT or ERR immediately on reset assertion mid-operation; no bus_err_o after deassertion.

Structure
REQ-030 SHALL place state encodings and stall/flush bit-index constants in shared package core_defs.
REQ-031 SHALL be a single module, no sub-modules; instantiated in core alongside pipeline registers.

Verification
REQ-032 SHALL test load-use: ex load to x5, de_rs1_addr=5, de_rs1_used=1 -> one cycle stall_o=5'b00011, flush_o=4'b0010; ex_wr_reg_addr=0 -> no stall.
REQ-033 SHALL test jump: ex_jump_req=1, ex_jump_addr=32'h0000_0100 -> pc_jump_en=1, addr 0x100, flush_o=4'b0011 same cycle.
REQ-034 SHALL test memory wait: lsu_req=1, lsu_ack after 3 cycles -> stall_o=5'b01111 for 3 cycles, 0 on ack cycle.
REQ-035 SHALL test timeout: TIMEOUT_CYC=4, no ack -> ERR after 4 wait cycles, bus_err_o one-cycle pulse, pc_jump_addr=TRAP_ADDR, flush_o=4'b1111.
REQ-036 SHALL test priority: ex_mc_busy=1 with ex_jump_req=1 -> stall_o=5'b00111, pc_jump_en=0; jump taken cycle after busy drops.
REQ-037 SHALL test reset in MEM_WAIT at count 2 -> outputs 0, RUN after release, no bus_err_o.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared core definitions: hazard FSM states and
// per-stage stall/flush bit positions.
package core_defs;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } ctrl_state_t;

  localparam int STALL_PC      = 0;
  localparam int STALL_IFU_DE  = 1;
  localparam int STALL_DE_ALU  = 2;
  localparam int STALL_ALU_LSU = 3;
  localparam int STALL_LSU_WB  = 4;

  localparam int FLUSH_IFU_DE  = 0;
  localparam int FLUSH_DE_ALU  = 1;
  localparam int FLUSH_ALU_LSU = 2;
  localparam int FLUSH_LSU_WB  = 3;

  // Hold every stage from pc up to and including stage k.
  function automatic logic [4:0] stall_upto(input int k);
    logic [4:0] m;
    m = '0;
    for (int i = 0; i < 5; i++)
      if (i <= k) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-control bundle between the pipeline
// datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if;
  logic [4:0]  de_rs1_addr;
  logic [4:0]  de_rs2_addr;
  logic        de_rs1_used;
  logic        de_rs2_used;
  logic        ex_wr_reg_en;
  logic [4:0]  ex_wr_reg_addr;
  logic        ex_is_load;
  logic        ex_jump_req;
  logic [31:0] ex_jump_addr;
  logic        ex_mc_busy;
  logic        lsu_req;
  logic        lsu_ack;
  logic [4:0]  stall_o;
  logic [3:0]  flush_o;
  logic        pc_jump_en;
  logic [31:0] pc_jump_addr;
  logic        bus_err_o;

  modport master (
    output de_rs1_addr, de_rs2_addr,
    output de_rs1_used, de_rs2_used,
    output ex_wr_reg_en, ex_wr_reg_addr,
    output ex_is_load,
    output ex_jump_req, ex_jump_addr,
    output ex_mc_busy,
    output lsu_req, lsu_ack,
    input  stall_o, flush_o,
    input  pc_jump_en, pc_jump_addr,
    input  bus_err_o
  );

  modport slave (
    input  de_rs1_addr, de_rs2_addr,
    input  de_rs1_used, de_rs2_used,
    input  ex_wr_reg_en, ex_wr_reg_addr,
    input  ex_is_load,
    input  ex_jump_req, ex_jump_addr,
    input  ex_mc_busy,
    input  lsu_req, lsu_ack,
    output stall_o, flush_o,
    output pc_jump_en, pc_jump_addr,
    output bus_err_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stalls, flushes,
// redirects and data-bus timeout trap.
module pipe_ctrl
  import core_defs::*;
#(
  parameter logic [7:0]  TIMEOUT_CYC = 8'd255,
  parameter logic [31:0] TRAP_ADDR   = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  ctrl_state_t state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;

  logic        mem_wait;
  logic        mc_hit;
  logic        jmp_hit;
  logic        lu_hit;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        lu_raw;

  logic [4:0]  stall;
  logic [3:0]  flush;
  logic        jmp_en;
  logic [31:0] jmp_addr;
  logic        berr;

  assign rs1_hit = bus.de_rs1_used &&
                   bus.de_rs1_addr == bus.ex_wr_reg_addr;
  assign rs2_hit = bus.de_rs2_used &&
                   bus.de_rs2_addr == bus.ex_wr_reg_addr;
  assign lu_raw  = bus.ex_is_load && bus.ex_wr_reg_en &&
                   bus.ex_wr_reg_addr != 5'd0 &&
                   (rs1_hit || rs2_hit);

  // Mutually exclusive terms encode the priority order.
  assign mem_wait = bus.lsu_req && !bus.lsu_ack;
  assign mc_hit   = bus.ex_mc_busy && !mem_wait;
  assign jmp_hit  = bus.ex_jump_req && !bus.ex_mc_busy &&
                    !mem_wait;
  assign lu_hit   = lu_raw && !bus.ex_jump_req &&
                    !bus.ex_mc_busy && !mem_wait;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = '0;
    flush     = '0;
    jmp_en    = 1'b0;
    jmp_addr  = '0;
    berr      = 1'b0;
    unique case (state)
      ST_RUN: begin
        unique case (1'b1)
          mem_wait: begin
            stall               = stall_upto(STALL_ALU_LSU);
            flush[FLUSH_LSU_WB] = 1'b1;
            state_nxt           = ST_MEM_WAIT;
            cnt_nxt             = 8'd1;
          end
          mc_hit: begin
            stall                = stall_upto(STALL_DE_ALU);
            flush[FLUSH_ALU_LSU] = 1'b1;
          end
          jmp_hit: begin
            jmp_en              = 1'b1;
            jmp_addr            = bus.ex_jump_addr;
            flush[FLUSH_IFU_DE] = 1'b1;
            flush[FLUSH_DE_ALU] = 1'b1;
          end
          lu_hit: begin
            stall               = stall_upto(STALL_IFU_DE);
            flush[FLUSH_DE_ALU] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM_WAIT: begin
        if (bus.lsu_ack) begin
          state_nxt = ST_RUN;
          cnt_nxt   = 8'd0;
        end else begin
          stall               = stall_upto(STALL_ALU_LSU);
          flush[FLUSH_LSU_WB] = 1'b1;
          if (cnt == TIMEOUT_CYC)
            state_nxt = ST_ERR;
          else
            cnt_nxt = cnt + 8'd1;
        end
      end
      ST_ERR: begin
        berr      = 1'b1;
        jmp_en    = 1'b1;
        jmp_addr  = TRAP_ADDR;
        flush     = 4'b1111;
        state_nxt = ST_RUN;
        cnt_nxt   = 8'd0;
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are forced quiet for the whole reset window.
  assign bus.stall_o      = rst_n ? stall    : '0;
  assign bus.flush_o      = rst_n ? flush    : '0;
  assign bus.pc_jump_en   = rst_n ? jmp_en   : 1'b0;
  assign bus.pc_jump_addr = rst_n ? jmp_addr : '0;
  assign bus.bus_err_o    = rst_n ? berr     : 1'b0;

endmodule
